hazard_ctrl: RTL and testbench

- Pipeline hazard controller for the 5-stage MIPS core.
- Drives the hold/clear controls that the F/D, D/E and E/M pipeline registers consume. A register's active-low enable is tied to the matching Stall output, and its CLR is tied to the matching Flush output.
- Produces forwarding selects for the D and E stages.
- Owns the multi-cycle mul/div stall sequencer, which is the block's sequential part.

---
 rtl/hazard_ctrl_if.sv | 30 +++
 rtl/hazard_ctrl.sv | 80 ++++++++
 tb/tb_hazard_ctrl.sv | 135 +++++++++++++
 3 files changed

// File: rtl/hazard_ctrl_if.sv
// Hazard-control bundle between the 5-stage pipeline datapath and hazard_ctrl.
// master = pipeline side, slave = hazard controller side.
interface hazard_ctrl_if;
    logic [4:0] RsD, RtD, RsE, RtE;
    logic [4:0] WriteRegE, WriteRegM, WriteRegW;
    logic       RegWriteE, RegWriteM, RegWriteW;
    logic       MemtoRegE, MemtoRegM;
    logic       BranchD, JumpD, PCSrcD, MulDivStartE;
    logic       StallF, StallD, StallE;
    logic       FlushD, FlushE, FlushM;
    logic       ForwardAD, ForwardBD;
    logic [1:0] ForwardAE, ForwardBE;
    logic       MulDivBusy;

    modport master (
        output RsD, RtD, RsE, RtE, WriteRegE, WriteRegM, WriteRegW,
               RegWriteE, RegWriteM, RegWriteW, MemtoRegE, MemtoRegM,
               BranchD, JumpD, PCSrcD, MulDivStartE,
        input  StallF, StallD, StallE, FlushD, FlushE, FlushM,
               ForwardAD, ForwardBD, ForwardAE, ForwardBE, MulDivBusy
    );

    modport slave (
        input  RsD, RtD, RsE, RtE, WriteRegE, WriteRegM, WriteRegW,
               RegWriteE, RegWriteM, RegWriteW, MemtoRegE, MemtoRegM,
               BranchD, JumpD, PCSrcD, MulDivStartE,
        output StallF, StallD, StallE, FlushD, FlushE, FlushM,
               ForwardAD, ForwardBD, ForwardAE, ForwardBE, MulDivBusy
    );
endinterface

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: forwarding selects, load-use/branch stalls,
// flush generation and the multi-cycle mul/div stall sequencer.
module hazard_ctrl #(
    parameter int unsigned MD_LATENCY = 4,
    parameter int unsigned CNT_W      = 4
) (
    input  logic         clk,
    input  logic         rst,
    hazard_ctrl_if.slave hz
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       r_state;
    logic [CNT_W-1:0] r_cnt;

    logic       w_lwstall, w_brstall, w_mdstall, w_stall;
    logic       w_e_hit_rs, w_e_hit_rt, w_m_hit_rs, w_m_hit_rt;
    logic [1:0] w_fwd_ae, w_fwd_be;
    logic       w_fwd_ad, w_fwd_bd;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                S_IDLE: if (hz.MulDivStartE) begin
                    r_state <= S_BUSY;
                    r_cnt   <= CNT_W'(MD_LATENCY - 2);
                end
                S_BUSY: if (r_cnt == '0) r_state <= S_DONE;
                        else             r_cnt   <= r_cnt - 1'b1;
                // the finishing instruction is still in E, so its start is ignored here
                S_DONE: r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        w_fwd_ae = 2'b00;
        if (hz.RegWriteM && hz.RsE != '0 && hz.RsE == hz.WriteRegM)      w_fwd_ae = 2'b10;
        else if (hz.RegWriteW && hz.RsE != '0 && hz.RsE == hz.WriteRegW) w_fwd_ae = 2'b01;
        w_fwd_be = 2'b00;
        if (hz.RegWriteM && hz.RtE != '0 && hz.RtE == hz.WriteRegM)      w_fwd_be = 2'b10;
        else if (hz.RegWriteW && hz.RtE != '0 && hz.RtE == hz.WriteRegW) w_fwd_be = 2'b01;
    end

    assign w_fwd_ad = hz.RegWriteM && hz.RsD != '0 && hz.RsD == hz.WriteRegM;
    assign w_fwd_bd = hz.RegWriteM && hz.RtD != '0 && hz.RtD == hz.WriteRegM;

    assign w_lwstall = hz.MemtoRegE && hz.RtE != '0 &&
                       (hz.RsD == hz.RtE || hz.RtD == hz.RtE);

    assign w_e_hit_rs = hz.WriteRegE != '0 && hz.WriteRegE == hz.RsD;
    assign w_e_hit_rt = hz.WriteRegE != '0 && hz.WriteRegE == hz.RtD;
    assign w_m_hit_rs = hz.WriteRegM != '0 && hz.WriteRegM == hz.RsD;
    assign w_m_hit_rt = hz.WriteRegM != '0 && hz.WriteRegM == hz.RtD;
    assign w_brstall  = hz.BranchD &&
                        ((hz.RegWriteE && (w_e_hit_rs || w_e_hit_rt)) ||
                         (hz.MemtoRegM && (w_m_hit_rs || w_m_hit_rt)));

    assign w_mdstall = (r_state == S_IDLE && hz.MulDivStartE) || (r_state == S_BUSY);
    assign w_stall   = w_lwstall || w_brstall || w_mdstall;

    // every output is forced low while reset is held, independent of the clock
    assign hz.StallF     = !rst && w_stall;
    assign hz.StallD     = !rst && w_stall;
    assign hz.StallE     = !rst && w_mdstall;
    assign hz.FlushE     = !rst && (w_lwstall || w_brstall) && !w_mdstall;
    assign hz.FlushM     = !rst && w_mdstall;
    assign hz.FlushD     = !rst && (hz.PCSrcD || hz.JumpD) && !w_stall;
    assign hz.ForwardAD  = !rst && w_fwd_ad;
    assign hz.ForwardBD  = !rst && w_fwd_bd;
    assign hz.ForwardAE  = rst ? 2'b00 : w_fwd_ae;
    assign hz.ForwardBE  = rst ? 2'b00 : w_fwd_be;
    assign hz.MulDivBusy = !rst && (r_state == S_BUSY);
endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed-vector bench for hazard_ctrl with MD_LATENCY = 4.
module tb_hazard_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;

    hazard_ctrl_if hif ();

    hazard_ctrl #(.MD_LATENCY(4), .CNT_W(4)) dut (
        .clk (clk),
        .rst (rst),
        .hz  (hif)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_inputs();
        hif.RsD = '0; hif.RtD = '0; hif.RsE = '0; hif.RtE = '0;
        hif.WriteRegE = '0; hif.WriteRegM = '0; hif.WriteRegW = '0;
        hif.RegWriteE = 1'b0; hif.RegWriteM = 1'b0; hif.RegWriteW = 1'b0;
        hif.MemtoRegE = 1'b0; hif.MemtoRegM = 1'b0;
        hif.BranchD = 1'b0; hif.JumpD = 1'b0; hif.PCSrcD = 1'b0;
        hif.MulDivStartE = 1'b0;
    endtask

    // {StallF, StallD, StallE, FlushD, FlushE, FlushM, MulDivBusy}
    function automatic logic [6:0] ctl();
        return {hif.StallF, hif.StallD, hif.StallE, hif.FlushD,
                hif.FlushE, hif.FlushM, hif.MulDivBusy};
    endfunction

    initial begin
        clear_inputs();
        // hazardous inputs under reset: everything must still read 0
        hif.MulDivStartE = 1'b1; hif.MemtoRegE = 1'b1; hif.RtE = 5'd9; hif.RsD = 5'd9;
        hif.PCSrcD = 1'b1; hif.RegWriteM = 1'b1; hif.WriteRegM = 5'd9; hif.RsE = 5'd9;
        repeat (2) @(negedge clk);
        #1;
        check("reset_ctl", 32'(ctl()), 32'h0);
        check("reset_fwd", 32'({hif.ForwardAE, hif.ForwardBE, hif.ForwardAD, hif.ForwardBD}), 32'h0);

        @(negedge clk);
        clear_inputs();
        rst = 1'b0;

        // forwarding
        hif.RegWriteM = 1'b1; hif.WriteRegM = 5'd8;
        hif.RegWriteW = 1'b1; hif.WriteRegW = 5'd8; hif.RsE = 5'd8;
        #1 check("fwdAE_M_wins", 32'(hif.ForwardAE), 32'h2);
        hif.RegWriteM = 1'b0;
        #1 check("fwdAE_W", 32'(hif.ForwardAE), 32'h1);
        hif.RegWriteM = 1'b1; hif.WriteRegM = 5'd0; hif.WriteRegW = 5'd0; hif.RsE = 5'd0;
        #1 check("fwdAE_r0", 32'(hif.ForwardAE), 32'h0);
        hif.RtE = 5'd12; hif.WriteRegW = 5'd12; hif.WriteRegM = 5'd7;
        #1 check("fwdBE_W", 32'(hif.ForwardBE), 32'h1);
        hif.RsD = 5'd7; hif.RtD = 5'd6;
        #1 check("fwdAD_BD", 32'({hif.ForwardAD, hif.ForwardBD}), 32'h2);
        hif.RsD = 5'd0; hif.WriteRegM = 5'd0;
        #1 check("fwdAD_r0", 32'({hif.ForwardAD, hif.ForwardBD}), 32'h0);

        // load-use
        @(negedge clk);
        clear_inputs();
        hif.MemtoRegE = 1'b1; hif.RtE = 5'd9; hif.RsD = 5'd9;
        #1 check("lw_stall", 32'(ctl()), 32'b1100100);
        @(negedge clk);
        hif.MemtoRegE = 1'b0;
        #1 check("lw_release", 32'(ctl()), 32'h0);

        // taken branch / jump
        @(negedge clk);
        clear_inputs();
        hif.PCSrcD = 1'b1;
        #1 check("br_taken_flushD", 32'(ctl()), 32'b0001000);
        hif.BranchD = 1'b1; hif.RegWriteE = 1'b1; hif.WriteRegE = 5'd5; hif.RsD = 5'd5;
        #1 check("br_stall", 32'(ctl()), 32'b1100100);
        hif.RegWriteE = 1'b0; hif.MemtoRegM = 1'b1; hif.WriteRegM = 5'd5;
        hif.RsD = 5'd1; hif.RtD = 5'd5;
        #1 check("br_stall_loadM", 32'(ctl()), 32'b1100100);
        clear_inputs();
        hif.JumpD = 1'b1;
        #1 check("jump_flushD", 32'(ctl()), 32'b0001000);

        // mul/div together with load-use
        @(negedge clk);
        clear_inputs();
        hif.MulDivStartE = 1'b1; hif.MemtoRegE = 1'b1; hif.RtE = 5'd3; hif.RsD = 5'd3;
        hif.PCSrcD = 1'b1;
        #1 check("md_lw_combo", 32'(ctl()), 32'b1110010);
        @(negedge clk);
        clear_inputs();
        repeat (5) @(negedge clk);
        #1 check("md_drained", 32'(ctl()), 32'h0);

        // mul/div sequence with start held high
        @(negedge clk);
        hif.MulDivStartE = 1'b1;
        #1 check("md_c1_detect", 32'(ctl()), 32'b1110010);
        for (int c = 2; c <= 4; c++) begin
            @(negedge clk);
            #1 check($sformatf("md_c%0d_busy", c), 32'(ctl()), 32'b1110011);
        end
        @(negedge clk);
        #1 check("md_c5_done", 32'(ctl()), 32'h0);
        @(negedge clk);
        #1 check("md_c6_restart", 32'(ctl()), 32'b1110010);
        @(negedge clk);
        #1 check("md_c7_busy", 32'(ctl()), 32'b1110011);

        // asynchronous reset in the middle of BUSY
        #2 rst = 1'b1;
        #1 check("async_rst_drop", 32'(ctl()), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        hif.MulDivStartE = 1'b0;
        #1 check("post_rst_idle", 32'(ctl()), 32'h0);
        hif.MulDivStartE = 1'b1;
        #1 check("post_rst_detect", 32'(ctl()), 32'b1110010);
        @(negedge clk);
        hif.MulDivStartE = 1'b0;
        #1 check("post_rst_busy", 32'(ctl()), 32'b1110011);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
